// File: rtl/fib_dispatch_pkg.sv
// Shared name geometry, dispatcher state encoding and a saturating counter helper.
`timescale 1ns / 1ps
package fib_dispatch_pkg;

    localparam int unsigned WORD_SIZE       = 32;
    localparam int unsigned MAX_NAME_LENGTH = 8;
    localparam int unsigned NW              = WORD_SIZE * MAX_NAME_LENGTH;

    typedef logic [NW-1:0] name_t;

    typedef enum logic {IDLE, HOLD} dispatch_state_e;

    // 32-bit add of a small increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/dual_issue_name_dispatcher_if.sv
// Host-side and lane-side signals of the dual-issue name dispatcher.
`timescale 1ns / 1ps
interface dual_issue_name_dispatcher_if
    import fib_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    name_t           name_in;
    logic            name_valid_in;
    logic            name_ready_out;
    name_t           name_out_1;
    logic            name_valid_out_1;
    name_t           name_out_2;
    logic            name_valid_out_2;
    logic            issue_strobe_out;
    logic [CntW-1:0] fifo_count_out;
    logic [31:0]     stat_names_out;
    logic [31:0]     stat_single_out;

    modport master (
        output name_in, name_valid_in,
        input  name_ready_out, name_out_1, name_valid_out_1, name_out_2, name_valid_out_2,
        input  issue_strobe_out, fifo_count_out, stat_names_out, stat_single_out
    );

    modport slave (
        input  name_in, name_valid_in,
        output name_ready_out, name_out_1, name_valid_out_1, name_out_2, name_valid_out_2,
        output issue_strobe_out, fifo_count_out, stat_names_out, stat_single_out
    );

endinterface

// File: rtl/name_fifo.sv
// Name FIFO with single push, pop of one or two entries, and peek of the two oldest entries.
`timescale 1ns / 1ps
module name_fifo
    import fib_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  name_t                       push_data_i,
    input  logic                        push_i,
    input  logic                        pop1_i,
    input  logic                        pop2_i,
    output name_t                       peek0_o,
    output name_t                       peek1_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        ready_o
);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    name_t            mem_q [FIFO_DEPTH];
    logic [AddrW:0]   wr_q, wr_d, rd_q, rd_d;
    logic             ready_q;
    logic [AddrW-1:0] rd_idx1;

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_d = wr_q + {{AddrW{1'b0}}, push_i};
        rd_d = rd_q;
        if (pop2_i) begin
            rd_d = rd_q + (AddrW + 1)'(2);
        end else if (pop1_i) begin
            rd_d = rd_q + (AddrW + 1)'(1);
        end
    end

    // Pointers and ready; ready is registered from the post-edge occupancy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= ((wr_d - rd_d) != (AddrW + 1)'(FIFO_DEPTH));
        end
    end

    // Storage needs no reset; entries are only read once the pointers say they are valid.
    always_ff @(posedge clk_in) begin
        if (push_i) begin
            mem_q[wr_q[AddrW-1:0]] <= push_data_i;
        end
    end

    assign rd_idx1 = rd_q[AddrW-1:0] + AddrW'(1);
    assign peek0_o = mem_q[rd_q[AddrW-1:0]];
    assign peek1_o = mem_q[rd_idx1];
    assign count_o = wr_q - rd_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/dual_issue_name_dispatcher.sv
// Dual-issue name dispatcher: buffers host names and issues up to two per slot, each slot held
// for HOLD_CYCLES clocks. Optional issue statistics are enabled by defining ISSUE_STATS_EN.
`timescale 1ns / 1ps
module dual_issue_name_dispatcher
    import fib_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input logic                         clk_in,
    input logic                         rst_n_in,
    dual_issue_name_dispatcher_if.slave disp_io
);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);

    dispatch_state_e  state_q;
    logic [HoldW-1:0] hold_q;
    name_t            lane1_q, lane2_q;
    logic             valid1_q, valid2_q, strobe_q;

    logic [CntW-1:0]  count;
    name_t            peek0, peek1;
    logic             ready, push, load, load_two;

    assign push     = disp_io.name_valid_in & ready;
    assign load_two = (count >= CntW'(2));
    // A slot loads from IDLE, or back-to-back at the end of a hold, whenever a name is waiting.
    assign load     = (count != '0) && ((state_q == IDLE) || (hold_q == '0));

    name_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_data_i (disp_io.name_in),
        .push_i      (push),
        .pop1_i      (load & ~load_two),
        .pop2_i      (load & load_two),
        .peek0_o     (peek0),
        .peek1_o     (peek1),
        .count_o     (count),
        .ready_o     (ready)
    );

    // Slot FSM with registered lane outputs and issue strobe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            lane1_q  <= '0;
            lane2_q  <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= load;
            if (load) begin
                state_q  <= HOLD;
                hold_q   <= HoldInit;
                lane1_q  <= peek0;
                lane2_q  <= load_two ? peek1 : '0;
                valid1_q <= 1'b1;
                valid2_q <= load_two;
            end else if (state_q == HOLD) begin
                if (hold_q == '0) begin
                    state_q  <= IDLE;
                    valid1_q <= 1'b0;
                    valid2_q <= 1'b0;
                end else begin
                    hold_q <= hold_q - 1'b1;
                end
            end
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_names_q, stat_single_q;

    // Saturating counts of names issued and of single-name slots.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_names_q  <= '0;
            stat_single_q <= '0;
        end else if (load) begin
            stat_names_q <= sat_add32(stat_names_q, load_two ? 2'd2 : 2'd1);
            if (!load_two) begin
                stat_single_q <= sat_add32(stat_single_q, 2'd1);
            end
        end
    end

    assign disp_io.stat_names_out  = stat_names_q;
    assign disp_io.stat_single_out = stat_single_q;
`else
    assign disp_io.stat_names_out  = '0;
    assign disp_io.stat_single_out = '0;
`endif

    assign disp_io.name_ready_out   = ready;
    assign disp_io.fifo_count_out   = count;
    assign disp_io.name_out_1       = lane1_q;
    assign disp_io.name_out_2       = lane2_q;
    assign disp_io.name_valid_out_1 = valid1_q;
    assign disp_io.name_valid_out_2 = valid2_q;
    assign disp_io.issue_strobe_out = strobe_q;

endmodule

// File: tb/tb_dual_issue_name_dispatcher.sv
// Bench for dual_issue_name_dispatcher: HOLD_CYCLES=16 instance driven from a vector table and
// hand sequences, plus a HOLD_CYCLES=1 instance for single-clock slots.
`timescale 1ns / 1ps
module tb_dual_issue_name_dispatcher;
    import fib_dispatch_pkg::*;

`ifdef ISSUE_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dual_issue_name_dispatcher_if #(.FIFO_DEPTH(4)) bus0 ();
    dual_issue_name_dispatcher_if #(.FIFO_DEPTH(4)) bus1 ();

    dual_issue_name_dispatcher #(
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (16)
    ) u_dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .disp_io  (bus0)
    );

    dual_issue_name_dispatcher #(
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (1)
    ) u_dut1 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .disp_io  (bus1)
    );

    typedef struct {
        int         idle;
        logic       vld;
        logic [7:0] tag;
        logic       stb, v1, v2;
        logic [7:0] t1, t2;
        int         cnt;
        logic       rdy;
    } vec_t;

    vec_t vecs [18];

    function automatic name_t mk(input logic [7:0] tag);
        name_t n;
        for (int w = 0; w < int'(MAX_NAME_LENGTH); w++) begin
            n[w*WORD_SIZE +: WORD_SIZE] = {tag, 8'(w), 16'hC0DE};
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step0(input logic v, input name_t n);
        bus0.name_valid_in = v;
        bus0.name_in       = n;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input name_t n);
        bus1.name_valid_in = v;
        bus1.name_in       = n;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        vec_t r;
        r = vecs[i];
        repeat (r.idle) step0(1'b0, '0);
        step0(r.vld, mk(r.tag));
        chk($sformatf("vec%0d_strobe", i), bus0.issue_strobe_out, r.stb);
        chk($sformatf("vec%0d_valid1", i), bus0.name_valid_out_1, r.v1);
        chk($sformatf("vec%0d_valid2", i), bus0.name_valid_out_2, r.v2);
        chk($sformatf("vec%0d_count", i), bus0.fifo_count_out, r.cnt);
        chk($sformatf("vec%0d_ready", i), bus0.name_ready_out, r.rdy);
        if (r.v1) begin
            chk($sformatf("vec%0d_lane1", i), bus0.name_out_1, mk(r.t1));
            chk($sformatf("vec%0d_lane2", i), bus0.name_out_2, r.v2 ? mk(r.t2) : '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nxt, exp_tag, prev, cyc;
        logic vcur, rdy_b, done;
        name_t h1, h2;

        // idle, vld, tag, stb, v1, v2, t1, t2, cnt, rdy
        vecs[0]  = '{0,  1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1, 1'b1};
        vecs[1]  = '{0,  1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 1, 1'b1};
        vecs[2]  = '{14, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1, 1'b1};
        vecs[3]  = '{0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 0, 1'b1};
        vecs[4]  = '{14, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 0, 1'b1};
        vecs[5]  = '{0,  1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0, 1'b1};
        vecs[6]  = '{0,  1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1, 1'b1};
        vecs[7]  = '{0,  1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0, 1, 1'b1};
        vecs[8]  = '{0,  1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 2, 1'b1};
        vecs[9]  = '{0,  1'b1, 8'd6, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 3, 1'b1};
        vecs[10] = '{0,  1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 4, 1'b0};
        vecs[11] = '{0,  1'b1, 8'd8, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 4, 1'b0};
        vecs[12] = '{10, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 4, 1'b0};
        vecs[13] = '{0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd5, 2, 1'b1};
        vecs[14] = '{14, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd5, 2, 1'b1};
        vecs[15] = '{0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd6, 8'd7, 0, 1'b1};
        vecs[16] = '{14, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd6, 8'd7, 0, 1'b1};
        vecs[17] = '{0,  1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0, 1'b1};

        bus0.name_valid_in = 1'b0;
        bus0.name_in       = '0;
        bus1.name_valid_in = 1'b0;
        bus1.name_in       = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus0.name_ready_out, 1'b1);
        chk("rst_count", bus0.fifo_count_out, 0);
        chk("rst_valid1", bus0.name_valid_out_1, 1'b0);
        chk("rst_strobe", bus0.issue_strobe_out, 1'b0);
        rst_n = 1'b1;

        // Single-name slots, then a full FIFO drained as pairs.
        for (int i = 0; i < 18; i++) apply_vec(i);

        // Continuous stream: fixed strobe period, stable lanes, order preserved.
        nxt = 20; exp_tag = 20; prev = -1; done = 1'b0; h1 = '0; h2 = '0;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            vcur  = (nxt < 28);
            rdy_b = bus0.name_ready_out;
            step0(vcur, mk(8'(nxt)));
            if (vcur && rdy_b) nxt++;
            if (bus0.issue_strobe_out) begin
                if (prev >= 0) chk("stream_period", cyc - prev, 16);
                prev = cyc;
                chk("stream_valid1", bus0.name_valid_out_1, 1'b1);
                h1 = mk(8'(exp_tag));
                chk("stream_lane1", bus0.name_out_1, h1);
                exp_tag++;
                h2 = '0;
                if (bus0.name_valid_out_2) begin
                    h2 = mk(8'(exp_tag));
                    chk("stream_lane2", bus0.name_out_2, h2);
                    exp_tag++;
                end
            end else if (bus0.name_valid_out_1) begin
                chk("stream_hold1", bus0.name_out_1, h1);
                chk("stream_hold2", bus0.name_out_2, h2);
            end
            done = (exp_tag == 28) && !bus0.name_valid_out_1;
        end
        chk("stream_done", done, 1'b1);

        // Asynchronous reset in the middle of a hold with three names buffered.
        step0(1'b1, mk(8'd30));
        step0(1'b1, mk(8'd31));
        step0(1'b1, mk(8'd32));
        step0(1'b1, mk(8'd33));
        repeat (3) step0(1'b0, '0);
        chk("prerst_count", bus0.fifo_count_out, 3);
        chk("prerst_lane1", bus0.name_out_1, mk(8'd30));
        #1 rst_n = 1'b0;
        #0.5;
        chk("midrst_valid1", bus0.name_valid_out_1, 1'b0);
        chk("midrst_valid2", bus0.name_valid_out_2, 1'b0);
        chk("midrst_lane1", bus0.name_out_1, '0);
        chk("midrst_strobe", bus0.issue_strobe_out, 1'b0);
        chk("midrst_count", bus0.fifo_count_out, 0);
        chk("midrst_ready", bus0.name_ready_out, 1'b1);
        #0.5 rst_n = 1'b1;
        step0(1'b1, mk(8'd40));
        chk("postrst_count", bus0.fifo_count_out, 1);
        step0(1'b0, '0);
        chk("postrst_strobe", bus0.issue_strobe_out, 1'b1);
        chk("postrst_lane1", bus0.name_out_1, mk(8'd40));
        chk("postrst_valid2", bus0.name_valid_out_2, 1'b0);
        chk("postrst_lane2", bus0.name_out_2, '0);
        repeat (16) step0(1'b0, '0);
        chk("postrst_idle", bus0.name_valid_out_1, 1'b0);

        // Statistics over one single slot and one pair slot.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("stat_rst_names", bus0.stat_names_out, 0);
        chk("stat_rst_single", bus0.stat_single_out, 0);
        step0(1'b1, mk(8'd50));
        step0(1'b1, mk(8'd51));
        chk("stat1_names", bus0.stat_names_out, StatsOn ? 1 : 0);
        chk("stat1_single", bus0.stat_single_out, StatsOn ? 1 : 0);
        step0(1'b1, mk(8'd52));
        repeat (15) step0(1'b0, '0);
        chk("stat2_strobe", bus0.issue_strobe_out, 1'b1);
        chk("stat2_lane1", bus0.name_out_1, mk(8'd51));
        chk("stat2_lane2", bus0.name_out_2, mk(8'd52));
        chk("stat2_names", bus0.stat_names_out, StatsOn ? 3 : 0);
        chk("stat2_single", bus0.stat_single_out, StatsOn ? 1 : 0);

        // HOLD_CYCLES=1: a fresh slot every clock, then valids drop.
        for (int k = 0; k < 6; k++) begin
            step1(k < 5, mk(8'(60 + k)));
            if (k >= 1) begin
                chk($sformatf("h1_strobe%0d", k), bus1.issue_strobe_out, 1'b1);
                chk($sformatf("h1_lane1_%0d", k), bus1.name_out_1, mk(8'(59 + k)));
                chk($sformatf("h1_valid2_%0d", k), bus1.name_valid_out_2, 1'b0);
            end
        end
        step1(1'b0, '0);
        chk("h1_idle_valid1", bus1.name_valid_out_1, 1'b0);
        chk("h1_idle_strobe", bus1.issue_strobe_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
